uart_rx: RTL and testbench

UART receiver. It deserialises an asynchronous 8N1 serial line into parallel bytes and runs in the same system-clock domain as the baud divider. Bit timing comes from an internal per-bit counter, so no separate baud clock is consumed. Output is a one-cycle valid pulse per byte plus a framing-error flag, for the downstream command/FIFO logic.

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser and an internal per-bit counter.
// Ports: clk, rst (async, active-high), rx in; rx_data, rx_valid, frame_error, busy out.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d;
    logic                 ferr_d;
    logic [1:0]           sync_q;
    logic                 rx_s;

    // Synchroniser resets to the idle (high) line level.
    assign rx_s = sync_q[1];
    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            sync_q      <= 2'b11;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            sync_q      <= {sync_q[0], rx};
            rx_data     <= data_d;
            rx_valid    <= valid_d;
            frame_error <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            // Re-check the start bit at its middle to reject glitches.
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end

            // LSB arrives first, so shift right and insert at the MSB.
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            // Leaving mid-stop-bit allows a back-to-back start bit.
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end

            // A held-low line must not be decoded as further frames.
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8).
// Table-driven frames, hand-written corner sequences and randomized frames vs. an ideal-UART model.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_error;
    logic          busy;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    int         nvalid = 0;
    int         nferr = 0;
    bit         both_seen = 1'b0;
    logic [7:0] vdata_q[$];
    int         vtime_q[$];
    int         t_start;

    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid++;
            vdata_q.push_back(rx_data);
            vtime_q.push_back(cyc);
        end
        if (frame_error) nferr++;
        if (rx_valid && frame_error) both_seen = 1'b1;
    end

    typedef struct {
        logic [7:0] data;
        int         width;
        bit         stop_good;
        int         hold;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act,
                              input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +-%0d", name, act, exp, tol);
        end
    endtask

    task automatic clear_mon();
        nvalid = 0;
        nferr  = 0;
        vdata_q.delete();
        vtime_q.delete();
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit
    // (or, for a bad stop bit, after the extra low hold).
    task automatic send_frame(input logic [7:0] d, input int w,
                              input bit stop_good, input int hold_low);
        rx = 1'b0;
        t_start = cyc;
        repeat (w) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (w) @(negedge clk);
        end
        rx = stop_good;
        repeat (w) @(negedge clk);
        if (!stop_good) begin
            repeat (hold_low) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] model_last;
        logic [7:0] d;
        bit         good;
        int         hold;
        int         gap;
        logic [7:0] rd;

        vecs[0] = '{8'hA5, 16, 1'b1, 0,   1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 16, 1'b1, 0,   1, 8'h3C, 0};
        vecs[2] = '{8'h55, 16, 1'b0, 100, 0, 8'h3C, 1};
        vecs[3] = '{8'h81, 16, 1'b1, 0,   1, 8'h81, 0};
        vecs[4] = '{8'hC3, 15, 1'b1, 0,   1, 8'hC3, 0};
        vecs[5] = '{8'hC3, 17, 1'b1, 0,   1, 8'hC3, 0};

        rst = 1'b1;
        rx  = 1'b1;
        #23;
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 0);
        check("reset frame_error", frame_error, 0);
        check("reset busy", busy, 0);
        #4 rst = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send_frame(vecs[i].data, vecs[i].width, vecs[i].stop_good, vecs[i].hold);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d valid count", i), nvalid, vecs[i].exp_valid);
            check($sformatf("vec%0d ferr count", i), nferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d busy idle", i), busy, 0);
            if (vecs[i].exp_valid == 1 && vecs[i].width == CPB && vtime_q.size() > 0)
                check_near($sformatf("vec%0d latency", i), vtime_q[0] - t_start,
                           CPB / 2 + (DB + 1) * CPB + 2, 1);
        end

        // Start-bit glitch
        clear_mon();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("glitch busy high", busy, 1);
        repeat (40) @(negedge clk);
        check("glitch valid count", nvalid, 0);
        check("glitch ferr count", nferr, 0);
        check("glitch busy idle", busy, 0);
        clear_mon();
        send_frame(8'h3C, CPB, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("post-glitch valid count", nvalid, 1);
        check("post-glitch rx_data", rx_data, 8'h3C);

        // Back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'h00, CPB, 1'b1, 0);
        send_frame(8'hFF, CPB, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("b2b valid count", nvalid, 2);
        check("b2b ferr count", nferr, 0);
        if (vdata_q.size() >= 2) begin
            check("b2b first byte", vdata_q[0], 8'h00);
            check("b2b second byte", vdata_q[1], 8'hFF);
            check_near("b2b spacing", vtime_q[1] - vtime_q[0], (DB + 2) * CPB, 1);
        end

        // Randomized frames vs. ideal UART: good stop delivers the byte,
        // bad stop gives one frame error and keeps the previous byte.
        model_last = 8'hFF;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            hold = $urandom_range(0, 40);
            gap  = $urandom_range(1, 25) + (good ? 0 : 5);
            clear_mon();
            send_frame(d, CPB, good, hold);
            repeat (gap) @(negedge clk);
            if (good) model_last = d;
            check($sformatf("rand%0d valid count", n), nvalid, good ? 1 : 0);
            check($sformatf("rand%0d ferr count", n), nferr, good ? 0 : 1);
            check($sformatf("rand%0d rx_data", n), rx_data, model_last);
        end
        repeat (20) @(negedge clk);

        // Asynchronous reset during data bit 4
        rd = 8'h7E;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = rd[i];
            repeat (CPB) @(negedge clk);
        end
        rx = rd[4];
        repeat (5) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst rx_valid", rx_valid, 0);
        check("midrst frame_error", frame_error, 0);
        check("midrst rx_data", rx_data, 8'h00);
        rx = 1'b1;
        #27 rst = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        clear_mon();
        send_frame(8'h7E, CPB, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("post-rst valid count", nvalid, 1);
        check("post-rst ferr count", nferr, 0);
        check("post-rst rx_data", rx_data, 8'h7E);

        check("valid/ferr exclusive", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
